uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of byte-stream requesters (2..8).
REQ-002 Parameter MAX_BURST, default 16, SHALL set the maximum bytes per grant (1..255).
REQ-003 Clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Resetn  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 Enable  in  1  SHALL be the transmitter enable, qualifying byte acceptance.
REQ-006 cfg_mask  in  NUM_REQ  SHALL mark requester i eligible for arbitration when bit i = 1.
REQ-007 req_valid  in  NUM_REQ  SHALL indicate requester i has a byte available.
REQ-008 req_data  in  NUM_REQ*8  SHALL carry requester i's byte in bits [8i+7:8i].
REQ-009 req_last  in  NUM_REQ  SHALL mark requester i's current byte as end of packet.
REQ-010 req_ready  out  NUM_REQ  SHALL be a one-cycle pop strobe to requester i.
REQ-011 tx_ready  in  1  SHALL be the transmitter's Ready (idle, may accept a byte).
REQ-012 tx_w_en  out  1  SHALL present a byte to the transmitter.
REQ-013 tx_w_data  out  8  SHALL carry the presented byte.
REQ-014 busy  out  1  SHALL be high whenever state is not S_IDLE.
REQ-015 grant  out  3  SHALL give the index of the current owner; valid while busy.
REQ-016 bytes_sent  out  16  SHALL count accepted bytes, saturating at 0xFFFF.

Function
REQ-017 States SHALL be S_IDLE, S_FETCH, S_SEND.
REQ-018 S_IDLE: if any (req_valid & cfg_mask), the block SHALL select the first eligible index at or after rr_ptr (wrapping modulo NUM_REQ), register it in grant, clear burst_cnt, and go to S_FETCH; otherwise it SHALL remain in S_IDLE.
REQ-019 S_FETCH: if req_valid[grant], the block SHALL assert req_ready[grant] combinationally for that cycle, latch req_data/req_last of grant into a hold register, increment burst_cnt, and go to S_SEND; otherwise it SHALL release (REQ-022).
REQ-020 S_SEND: tx_w_en SHALL be 1 and tx_w_data SHALL equal the hold register; acceptance SHALL be Enable & tx_ready & tx_w_en in the same cycle.
REQ-021 On acceptance, bytes_sent SHALL increment (saturating); if the held byte was last or burst_cnt == MAX_BURST the block SHALL release, otherwise go to S_FETCH.
REQ-022 Release SHALL set rr_ptr to (grant+1) mod NUM_REQ and return to S_IDLE.
REQ-023 Without acceptance, S_SEND SHALL hold with tx_w_en and tx_w_data stable indefinitely (Enable low or tx_ready low).
REQ-024 Latency: valid seen in S_IDLE at cycle 0 -> req_ready at cycle 1 -> tx_w_en at cycle 2.
REQ-025 At most one req_ready bit SHALL be high in any cycle, and only in S_FETCH.
REQ-026 cfg_mask SHALL be sampled only in S_IDLE; clearing the owner's bit mid-burst SHALL NOT abort the burst.
REQ-027 A requester's req_valid dropping mid-burst SHALL cause release at the next S_FETCH, with no byte lost.
REQ-028 If the transmitter drops tx_ready the cycle after acceptance, the next byte SHALL wait in S_SEND; double acceptance SHALL be impossible by construction.

Reset
REQ-029 On Resetn low: state = S_IDLE, rr_ptr = 0, grant = 0, burst_cnt = 0, hold register = 0, bytes_sent = 0; tx_w_en = 0, req_ready = 0, busy = 0.
REQ-030 Reset mid-burst SHALL discard the held byte without a second pop.

Structure
REQ-031 The state enum, default NUM_REQ, and default MAX_BURST SHALL reside in shared package uart_pkg.
REQ-032 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs request vector and pointer; outputs index and any).

Verification
REQ-033 Only requester 1 is valid with 3 bytes 0x41,0x42,0x43, last on 0x43, tx_ready=1, Enable=1 -> three req_ready[1] pulses; tx_w_data sequence 41,42,43; bytes_sent=3; rr_ptr=2.
REQ-034 Requesters 0 and 2 are continuously valid with 1-byte packets -> grants alternate 0,2,0,2.
REQ-035 MAX_BURST=4; requester 3 streams 10 bytes with no last -> release after 4 bytes; with other requesters idle, it is regranted.
REQ-036 Enable=0 for 50 cycles during S_SEND with byte 0x5A -> tx_w_en held at 1 with data 0x5A; accepted on the first cycle Enable=1 and tx_ready=1.
REQ-037 cfg_mask=0b0001 with all requesters valid -> only requester 0 is granted; Resetn asserted in S_SEND -> all outputs reach REQ-029 values with no extra pops.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: state encoding and
// default sizing.
package uart_pkg;

  localparam int unsigned UART_NUM_REQ_DEF   = 4;
  localparam int unsigned UART_MAX_BURST_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first asserted request at or
// after the pointer, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    int unsigned w_cand;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = (32'(i_ptr) + k) % N;
      if (!o_any && i_req[IW'(w_cand)]) begin
        o_any = 1'b1;
        o_idx = IW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler feeding bytes from several requesters into one UART
// transmitter, with bounded bursts per grant.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ   = UART_NUM_REQ_DEF,
  parameter int unsigned MAX_BURST = UART_MAX_BURST_DEF
) (
  input  logic                 Clk,
  input  logic                 Resetn,
  input  logic                 Enable,
  input  logic [NUM_REQ-1:0]   cfg_mask,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 tx_ready,
  output logic                 tx_w_en,
  output logic [7:0]           tx_w_data,
  output logic                 busy,
  output logic [2:0]           grant,
  output logic [15:0]          bytes_sent
);

  localparam int unsigned GW = $clog2(NUM_REQ);

  sched_state_t  r_state;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_rr_ptr;
  logic [7:0]    r_burst_cnt;
  logic [7:0]    r_hold_data;
  logic          r_hold_last;
  logic [15:0]   r_bytes_sent;

  logic [GW-1:0] w_arb_idx;
  logic          w_arb_any;
  logic [GW-1:0] w_ptr_nxt;
  logic          w_fetch_pop;
  logic          w_accept;

  rr_arbiter #(.N(NUM_REQ), .IW(GW)) u_arb (
    .i_req (req_valid & cfg_mask),
    .i_ptr (r_rr_ptr),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  // The owner keeps its grant even if its mask bit clears mid-burst.
  assign w_fetch_pop = (r_state == S_FETCH) && req_valid[r_grant];
  assign w_accept    = Enable && tx_ready && tx_w_en;
  assign w_ptr_nxt   = (32'(r_grant) == NUM_REQ - 1) ? '0 : r_grant + 1'b1;

  always_comb begin
    req_ready = '0;
    if (w_fetch_pop) req_ready[r_grant] = 1'b1;
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_rr_ptr     <= '0;
      r_burst_cnt  <= '0;
      r_hold_data  <= '0;
      r_hold_last  <= 1'b0;
      r_bytes_sent <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_arb_any) begin
            r_grant     <= w_arb_idx;
            r_burst_cnt <= '0;
            r_state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (req_valid[r_grant]) begin
            r_hold_data <= req_data[{r_grant, 3'b000} +: 8];
            r_hold_last <= req_last[r_grant];
            r_burst_cnt <= r_burst_cnt + 1'b1;
            r_state     <= S_SEND;
          end else begin
            r_rr_ptr <= w_ptr_nxt;
            r_state  <= S_IDLE;
          end
        end
        S_SEND: begin
          if (w_accept) begin
            if (r_bytes_sent != '1) r_bytes_sent <= r_bytes_sent + 1'b1;
            if (r_hold_last || (r_burst_cnt == 8'(MAX_BURST))) begin
              r_rr_ptr <= w_ptr_nxt;
              r_state  <= S_IDLE;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_w_en    = (r_state == S_SEND);
  assign tx_w_data  = r_hold_data;
  assign busy       = (r_state != S_IDLE);
  assign grant      = 3'(r_grant);
  assign bytes_sent = r_bytes_sent;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: queue-based requesters and a
// transaction-level round-robin reference model.
module tb_uart_tx_scheduler;

  localparam int NR = 4;
  localparam int MB = 4;

  logic          Clk = 1'b0;
  logic          Resetn, Enable, tx_ready;
  logic [NR-1:0] cfg_mask, req_valid, req_last, req_ready;
  logic [NR*8-1:0] req_data;
  logic          tx_w_en, busy;
  logic [7:0]    tx_w_data;
  logic [2:0]    grant;
  logic [15:0]   bytes_sent;

  always #5 Clk = ~Clk;

  uart_tx_scheduler #(.NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .Clk(Clk), .Resetn(Resetn), .Enable(Enable), .cfg_mask(cfg_mask),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_ready(tx_ready), .tx_w_en(tx_w_en),
    .tx_w_data(tx_w_data), .busy(busy), .grant(grant), .bytes_sent(bytes_sent)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0]    rq[NR][$];      // {last, data} per requester
  logic [NR-1:0] vld_en;
  logic [10:0]   acc[$];         // observed {grant, data} acceptances
  logic [10:0]   exp_q[$];       // expected {owner, data}
  int            pops[NR];
  int            busy_fall, cyc, first_rdy, first_en, multi_rdy;
  logic          prev_busy;
  bit            rand_io;
  int            model_ptr, model_bytes;

  task automatic drive();
    logic [8:0] h;
    for (int i = 0; i < NR; i++) begin
      h = (rq[i].size() > 0) ? rq[i][0] : 9'h000;
      req_valid[i]      = vld_en[i] && (rq[i].size() > 0);
      req_data[i*8 +: 8] = h[7:0];
      req_last[i]       = h[8];
    end
  endtask

  task automatic clear_logs();
    acc.delete();
    for (int i = 0; i < NR; i++) pops[i] = 0;
    busy_fall = 0; cyc = 0; first_rdy = -1; first_en = -1; multi_rdy = 0;
  endtask

  task automatic load(input int r, input int len, input bit with_last);
    for (int j = 0; j < len; j++)
      rq[r].push_back({with_last && (j == len - 1), 8'($urandom)});
  endtask

  task automatic flush();
    for (int i = 0; i < NR; i++) rq[i].delete();
    drive();
  endtask

  // Observe mid-cycle, then apply pops and new inputs just after the edge.
  task automatic cycle();
    logic [NR-1:0] pop_now;
    @(negedge Clk);
    pop_now = req_ready;
    if ($countones(req_ready) > 1) multi_rdy++;
    if ((|req_ready) && first_rdy < 0) first_rdy = cyc;
    if (tx_w_en && first_en < 0) first_en = cyc;
    if (tx_w_en && Enable && tx_ready) acc.push_back({grant, tx_w_data});
    if (prev_busy && !busy) busy_fall++;
    prev_busy = busy;
    cyc++;
    @(posedge Clk); #1;
    for (int i = 0; i < NR; i++)
      if (pop_now[i]) begin
        pops[i]++;
        if (rq[i].size() > 0) void'(rq[i].pop_front());
      end
    if (rand_io) begin
      Enable   = ($urandom_range(0, 3) != 0);
      tx_ready = ($urandom_range(0, 2) != 0);
    end
    drive();
  endtask

  task automatic run(input int bound, output bit timed_out);
    int n = 0;
    while (!(acc.size() >= exp_q.size() && !busy) && n < bound) begin
      cycle();
      n++;
    end
    timed_out = (n >= bound);
    repeat (3) cycle();
  endtask

  // Packet-level reference: every eligible non-empty queue is served in
  // round-robin order; a grant ends on last, on MB bytes, or when empty.
  function automatic void model_run(input logic [NR-1:0] mask);
    logic [8:0] mq[NR][$];
    logic [8:0] b;
    int p, owner, n, c;
    bit found;
    exp_q.delete();
    for (int i = 0; i < NR; i++) mq[i] = rq[i];
    p = model_ptr;
    do begin
      found = 0; owner = 0;
      for (int k = 0; k < NR; k++) begin
        c = (p + k) % NR;
        if (!found && mask[c] && mq[c].size() > 0) begin found = 1; owner = c; end
      end
      if (found) begin
        n = 0;
        do begin
          b = mq[owner].pop_front();
          exp_q.push_back({3'(owner), b[7:0]});
          n++;
        end while (!b[8] && n < MB && mq[owner].size() > 0);
        p = (owner + 1) % NR;
      end
    end while (found);
    model_ptr = p;
  endfunction

  task automatic test_reset();
    Resetn = 1'b0;
    rq[0].push_back(9'h1AA);
    drive();
    repeat (3) @(posedge Clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (tx_w_en !== 1'b0) begin n_fail++; $display("FAIL reset_tx_w_en: got %b expected 0", tx_w_en); end
    n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    n_checks++; if (grant !== 3'd0) begin n_fail++; $display("FAIL reset_grant: got %0d expected 0", grant); end
    n_checks++; if (bytes_sent !== 16'd0) begin n_fail++; $display("FAIL reset_bytes_sent: got %0d expected 0", bytes_sent); end
    n_checks++; if (tx_w_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_w_data: got %02h expected 00", tx_w_data); end
    flush();
    @(posedge Clk); #1;
    Resetn = 1'b1;
    prev_busy = 1'b0;
  endtask

  task automatic test_single();
    bit to;
    clear_logs();
    Enable = 1'b1; tx_ready = 1'b1;
    rq[1].push_back(9'h041); rq[1].push_back(9'h042); rq[1].push_back(9'h143);
    drive();
    model_run(4'hF);
    model_bytes += exp_q.size();
    run(200, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL single_done: got timeout expected completion"); end
    n_checks++; if (first_rdy != 1) begin n_fail++; $display("FAIL single_ready_latency: got %0d expected 1", first_rdy); end
    n_checks++; if (first_en != 2) begin n_fail++; $display("FAIL single_wen_latency: got %0d expected 2", first_en); end
    n_checks++; if (pops[1] != 3) begin n_fail++; $display("FAIL single_pops: got %0d expected 3", pops[1]); end
    n_checks++; if (acc.size() != 3) begin n_fail++; $display("FAIL single_count: got %0d expected 3", acc.size()); end
    for (int k = 0; k < acc.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (acc[k] !== exp_q[k]) begin n_fail++; $display("FAIL single_byte[%0d]: got %03h expected %03h", k, acc[k], exp_q[k]); end
    end
    n_checks++; if (bytes_sent !== 16'(model_bytes)) begin n_fail++; $display("FAIL single_bytes_sent: got %0d expected %0d", bytes_sent, model_bytes); end
  endtask

  task automatic test_alternate();
    bit to;
    logic [10:0] a;
    clear_logs();
    for (int j = 0; j < 4; j++) begin load(0, 1, 1'b1); load(2, 1, 1'b1); end
    drive();
    model_run(4'hF);
    model_bytes += exp_q.size();
    run(300, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL alt_done: got timeout expected completion"); end
    n_checks++; if (acc.size() != exp_q.size()) begin n_fail++; $display("FAIL alt_count: got %0d expected %0d", acc.size(), exp_q.size()); end
    // Previous burst by requester 1 leaves the pointer at 2.
    for (int k = 0; k < acc.size() && k < exp_q.size(); k++) begin
      a = acc[k];
      n_checks++;
      if (acc[k] !== exp_q[k] || a[10:8] !== ((k % 2 == 0) ? 3'd2 : 3'd0)) begin
        n_fail++; $display("FAIL alt_byte[%0d]: got %03h expected %03h", k, acc[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_burst_limit();
    bit to;
    clear_logs();
    load(3, 10, 1'b0);
    drive();
    model_run(4'hF);
    model_bytes += exp_q.size();
    run(400, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL burst_done: got timeout expected completion"); end
    n_checks++; if (busy_fall != 3) begin n_fail++; $display("FAIL burst_releases: got %0d expected 3", busy_fall); end
    n_checks++; if (pops[3] != 10) begin n_fail++; $display("FAIL burst_pops: got %0d expected 10", pops[3]); end
    n_checks++; if (acc.size() != exp_q.size()) begin n_fail++; $display("FAIL burst_count: got %0d expected %0d", acc.size(), exp_q.size()); end
    for (int k = 0; k < acc.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (acc[k] !== exp_q[k]) begin n_fail++; $display("FAIL burst_byte[%0d]: got %03h expected %03h", k, acc[k], exp_q[k]); end
    end
  endtask

  task automatic test_enable_stall();
    int n = 0;
    clear_logs();
    Enable = 1'b0; tx_ready = 1'b1;
    rq[1].push_back(9'h15A);
    drive();
    model_run(4'hF);
    model_bytes += exp_q.size();
    while (first_en < 0 && n < 20) begin cycle(); n++; end
    n_checks++; if (first_en < 0) begin n_fail++; $display("FAIL stall_reach_send: got timeout expected tx_w_en"); end
    for (int k = 0; k < 50; k++) begin
      cycle();
      n_checks++;
      if (tx_w_en !== 1'b1 || tx_w_data !== 8'h5A || acc.size() != 0) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got en %b data %02h acc %0d expected en 1 data 5a acc 0", k, tx_w_en, tx_w_data, acc.size());
      end
    end
    Enable = 1'b1;
    cycle();
    n_checks++;
    if (acc.size() != 1 || acc[0] !== {3'd1, 8'h5A}) begin
      n_fail++; $display("FAIL stall_accept: got %0d accepts expected 1 of 15a", acc.size());
    end
    repeat (2) cycle();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_idle: got busy %b expected 0", busy); end
    n_checks++; if (bytes_sent !== 16'(model_bytes)) begin n_fail++; $display("FAIL stall_bytes_sent: got %0d expected %0d", bytes_sent, model_bytes); end
  endtask

  task automatic test_valid_drop();
    bit to;
    int n = 0;
    logic [8:0] h;
    clear_logs();
    load(2, 5, 1'b0);
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin h = rq[2][k]; exp_q.push_back({3'd2, h[7:0]}); end
    drive();
    while (pops[2] < 2 && n < 50) begin cycle(); n++; end
    vld_en[2] = 1'b0;
    drive();
    n = 0;
    while (!(busy_fall >= 1 && !busy) && n < 50) begin cycle(); n++; end
    n_checks++; if (acc.size() != 2) begin n_fail++; $display("FAIL drop_first_burst: got %0d bytes expected 2", acc.size()); end
    vld_en[2] = 1'b1;
    drive();
    run(200, to);
    model_ptr = 3;
    model_bytes += 5;
    n_checks++; if (to) begin n_fail++; $display("FAIL drop_done: got timeout expected completion"); end
    n_checks++; if (pops[2] != 5) begin n_fail++; $display("FAIL drop_pops: got %0d expected 5", pops[2]); end
    n_checks++; if (acc.size() != 5) begin n_fail++; $display("FAIL drop_count: got %0d expected 5", acc.size()); end
    for (int k = 0; k < acc.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (acc[k] !== exp_q[k]) begin n_fail++; $display("FAIL drop_byte[%0d]: got %03h expected %03h", k, acc[k], exp_q[k]); end
    end
  endtask

  task automatic test_mask();
    bit to;
    int n = 0;
    clear_logs();
    cfg_mask = 4'b0001;
    load(0, 3, 1'b1);
    for (int i = 1; i < NR; i++) load(i, 2, 1'b1);
    drive();
    model_run(4'b0001);
    model_bytes += exp_q.size();
    while (acc.size() < 1 && n < 50) begin cycle(); n++; end
    cfg_mask = 4'b0000;
    run(200, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL mask_done: got timeout expected completion"); end
    n_checks++; if (pops[0] != 3 || pops[1] + pops[2] + pops[3] != 0) begin
      n_fail++; $display("FAIL mask_pops: got %0d/%0d/%0d/%0d expected 3/0/0/0", pops[0], pops[1], pops[2], pops[3]);
    end
    n_checks++; if (acc.size() != exp_q.size()) begin n_fail++; $display("FAIL mask_count: got %0d expected %0d", acc.size(), exp_q.size()); end
    for (int k = 0; k < acc.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (acc[k] !== exp_q[k]) begin n_fail++; $display("FAIL mask_byte[%0d]: got %03h expected %03h", k, acc[k], exp_q[k]); end
    end
    flush();
    cfg_mask = '1;
  endtask

  task automatic test_reset_mid();
    bit to;
    int n = 0;
    clear_logs();
    Enable = 1'b0; tx_ready = 1'b1;
    load(1, 3, 1'b1);
    drive();
    while (first_en < 0 && n < 20) begin cycle(); n++; end
    repeat (2) cycle();
    @(negedge Clk);
    Resetn = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || tx_w_en !== 1'b0 || req_ready !== '0) begin
      n_fail++; $display("FAIL midreset_ctrl: got busy %b en %b rdy %b expected 0 0 0", busy, tx_w_en, req_ready);
    end
    n_checks++; if (grant !== 3'd0 || bytes_sent !== 16'd0 || tx_w_data !== 8'h00) begin
      n_fail++; $display("FAIL midreset_regs: got grant %0d bytes %0d data %02h expected 0 0 00", grant, bytes_sent, tx_w_data);
    end
    repeat (2) cycle();
    n_checks++; if (pops[1] != 1) begin n_fail++; $display("FAIL midreset_pops: got %0d expected 1", pops[1]); end
    Resetn = 1'b1;
    Enable = 1'b1;
    prev_busy = 1'b0;
    model_ptr = 0;
    model_bytes = 0;
    model_run(4'hF);
    model_bytes += exp_q.size();
    run(200, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL midreset_done: got timeout expected completion"); end
    n_checks++; if (pops[1] != 3) begin n_fail++; $display("FAIL midreset_total_pops: got %0d expected 3", pops[1]); end
    n_checks++; if (acc.size() != exp_q.size()) begin n_fail++; $display("FAIL midreset_count: got %0d expected %0d", acc.size(), exp_q.size()); end
    for (int k = 0; k < acc.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (acc[k] !== exp_q[k]) begin n_fail++; $display("FAIL midreset_byte[%0d]: got %03h expected %03h", k, acc[k], exp_q[k]); end
    end
    n_checks++; if (bytes_sent !== 16'(model_bytes)) begin n_fail++; $display("FAIL midreset_bytes_sent: got %0d expected %0d", bytes_sent, model_bytes); end
  endtask

  task automatic test_random();
    bit to;
    logic [NR-1:0] m;
    int tot;
    for (int r = 0; r < 6; r++) begin
      clear_logs();
      m = NR'($urandom_range(1, 15));
      cfg_mask = m;
      for (int i = 0; i < NR; i++)
        for (int p = $urandom_range(0, 3); p > 0; p--)
          load(i, $urandom_range(1, 6), ($urandom_range(0, 3) != 0));
      drive();
      model_run(m);
      model_bytes += exp_q.size();
      rand_io = 1'b1;
      run(3000, to);
      rand_io = 1'b0;
      Enable = 1'b1; tx_ready = 1'b1;
      tot = pops[0] + pops[1] + pops[2] + pops[3];
      n_checks++; if (to) begin n_fail++; $display("FAIL rand%0d_done: got timeout expected completion", r); end
      n_checks++; if (multi_rdy != 0) begin n_fail++; $display("FAIL rand%0d_onehot: got %0d multi-ready cycles expected 0", r, multi_rdy); end
      n_checks++; if (tot != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_pops: got %0d expected %0d", r, tot, exp_q.size()); end
      n_checks++; if (acc.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d", r, acc.size(), exp_q.size()); end
      for (int k = 0; k < acc.size() && k < exp_q.size(); k++) begin
        n_checks++;
        if (acc[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand%0d_byte[%0d]: got %03h expected %03h", r, k, acc[k], exp_q[k]); end
      end
      n_checks++; if (bytes_sent !== 16'(model_bytes)) begin n_fail++; $display("FAIL rand%0d_bytes_sent: got %0d expected %0d", r, bytes_sent, model_bytes); end
      flush();
      cfg_mask = '1;
    end
  endtask

  initial begin
    Resetn = 1'b0; Enable = 1'b0; tx_ready = 1'b0;
    cfg_mask = '1; vld_en = '1;
    req_valid = '0; req_data = '0; req_last = '0;
    rand_io = 1'b0; prev_busy = 1'b0;
    model_ptr = 0; model_bytes = 0;
    clear_logs();
    test_reset();
    test_single();
    test_alternate();
    test_burst_limit();
    test_enable_stall();
    test_valid_drop();
    test_mask();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
